// File: rtl/pipe_regfile_pkg.sv
// Shared register-file widths and a helper for slicing packed multi-port buses.
// Decode and write-back import the same defaults so their widths always agree.
package pipe_regfile_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int SLICE_MAX_W = 128;
  localparam int BUS_MAX_W   = 4 * SLICE_MAX_W;

  // Returns field idx of width w from a packed bus, zero-extended to SLICE_MAX_W.
  function automatic logic [SLICE_MAX_W-1:0] get_slice(
    input logic [BUS_MAX_W-1:0] bus,
    input int                   idx,
    input int                   w
  );
    logic [BUS_MAX_W-1:0]   shifted;
    logic [SLICE_MAX_W-1:0] res;
    res     = '0;
    shifted = bus >> (idx * w);
    for (int b = 0; b < SLICE_MAX_W; b++) begin
      if (b < w) res[b] = shifted[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set by issue, cleared by write-back, set wins on collision.
// rbusy is combinational and masked by a same-cycle write; any_busy reflects stored bits only.
module regfile_scoreboard
  import pipe_regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy,
  output logic                     any_busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              clr_en;
  logic              set_en;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    clr_en = we & ~rst;
    set_en = set_busy & ~rst;
    if (ZERO_REG != 0) begin
      if (waddr == '0)    clr_en = 1'b0;
      if (set_addr == '0) set_en = 1'b0;
    end
    busy_d = busy_q;
    if (clr_en) busy_d[waddr] = 1'b0;
    // A newly issued producer supersedes the one retiring this cycle.
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rbusy   = '0;
    rd_addr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr  = ADDR_W'(get_slice(BUS_MAX_W'(raddr), i, ADDR_W));
      rbusy[i] = busy_q[rd_addr] & ~(clr_en && (waddr == rd_addr));
      if ((ZERO_REG != 0) && (rd_addr == '0)) rbusy[i] = 1'b0;
    end
  end

  assign any_busy = |busy_q;

endmodule

// File: rtl/pipe_regfile.sv
// Parametrised register file with NUM_RD zero-latency read ports, write-back bypass and busy scoreboard.
// Writes and busy-sets land at the next rising edge; no backpressure, every write is accepted.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        set_addr,
  output logic                     any_busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    wr_en = we & ~rst;
    if ((ZERO_REG != 0) && (waddr == '0)) wr_en = 1'b0;
    rf_d = rf_q;
    if (wr_en) rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rf_q <= '{default: '0};
    else     rf_q <= rf_d;
  end

  // Hard-wired zero first, then the in-flight write-back value, then storage.
  always_comb begin
    rdata   = '0;
    rd_addr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr = ADDR_W'(get_slice(BUS_MAX_W'(raddr), i, ADDR_W));
      if ((ZERO_REG != 0) && (rd_addr == '0))
        rdata[i*DATA_W +: DATA_W] = '0;
      else if (wr_en && (waddr == rd_addr))
        rdata[i*DATA_W +: DATA_W] = wdata;
      else
        rdata[i*DATA_W +: DATA_W] = rf_q[rd_addr];
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .NUM_RD   (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .raddr    (raddr),
    .rbusy    (rbusy),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_pipe_regfile.sv
// Bench: directed checks on default and ZERO_REG=0 instances, then random traffic on a 64x16x3 instance.
module tb_pipe_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Shared stimulus for the two 32-bit / 5-bit / 2-port instances
  logic        we, set_busy;
  logic [4:0]  waddr, set_addr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic        any_a, any_b;

  // Wide instance
  logic         we_w, set_w;
  logic [3:0]   waddr_w, saddr_w;
  logic [63:0]  wdata_w;
  logic [11:0]  raddr_w;
  logic [191:0] rdata_w;
  logic [2:0]   rbusy_w;
  logic         any_w;

  pipe_regfile u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .set_busy(set_busy), .set_addr(set_addr), .any_busy(any_a)
  );

  pipe_regfile #(.ZERO_REG(0)) u_nozero (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .set_busy(set_busy), .set_addr(set_addr), .any_busy(any_b)
  );

  pipe_regfile #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1)) u_wide (
    .clk(clk), .rst(rst), .we(we_w), .waddr(waddr_w), .wdata(wdata_w),
    .raddr(raddr_w), .rdata(rdata_w), .rbusy(rbusy_w),
    .set_busy(set_w), .set_addr(saddr_w), .any_busy(any_w)
  );

  logic [63:0] m_rf   [16];
  logic        m_busy [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic sb, input logic [4:0] sa);
    we = w; waddr = wa; wdata = wd; raddr = {r1, r0};
    set_busy = sb; set_addr = sa;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  ra;
    logic [63:0] exp_d;
    logic        exp_b;
    logic        exp_any;

    we_w = 1'b0; set_w = 1'b0; waddr_w = '0; saddr_w = '0; wdata_w = '0; raddr_w = '0;

    // While in reset, writes and sets are ignored and outputs stay zero
    drv(1, 5, 32'hAAAA_5555, 5, 6, 1, 6);
    chk("rst_rdata_a", rdata_a, 64'h0);
    chk("rst_rdata_b", rdata_b, 64'h0);
    chk("rst_rbusy_a", 64'(rbusy_a), 64'h0);
    tick();
    chk("rst_any_a", 64'(any_a), 64'h0);
    chk("rst_any_b", 64'(any_b), 64'h0);
    chk("rst_hold_r5", 64'(rdata_a[31:0]), 64'h0);
    rst = 1'b0;
    drv(0, 0, 0, 5, 6, 0, 0);
    tick();
    chk("post_rst_r5", 64'(rdata_a[31:0]), 64'h0);
    chk("post_rst_any", 64'(any_a), 64'h0);

    // Write with same-cycle bypass, then readback from storage
    drv(1, 7, 32'hDEAD_BEEF, 7, 8, 0, 0);
    chk("byp_r7", 64'(rdata_a[31:0]), 64'hDEAD_BEEF);
    chk("byp_r8_p1", 64'(rdata_a[63:32]), 64'h0);
    chk("byp_r7_nz", 64'(rdata_b[31:0]), 64'hDEAD_BEEF);
    tick();
    drv(0, 0, 0, 7, 8, 0, 0);
    chk("store_r7", 64'(rdata_a[31:0]), 64'hDEAD_BEEF);
    chk("store_r8", 64'(rdata_a[63:32]), 64'h0);

    // Register 0: hard-wired on u_dut, ordinary on u_nozero
    drv(1, 0, 32'h1234, 0, 0, 1, 0);
    chk("z_byp_a", 64'(rdata_a[31:0]), 64'h0);
    chk("z_byp_b", 64'(rdata_b[31:0]), 64'h1234);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("z_rd_a", 64'(rdata_a[31:0]), 64'h0);
    chk("z_busy_a", 64'(rbusy_a[0]), 64'h0);
    chk("z_any_a", 64'(any_a), 64'h0);
    chk("z_rd_b", 64'(rdata_b[31:0]), 64'h1234);
    chk("z_busy_b", 64'(rbusy_b[0]), 64'h1);
    chk("z_any_b", 64'(any_b), 64'h1);
    drv(1, 0, 32'h1234, 0, 0, 0, 0);
    chk("z_clr_rbusy_b", 64'(rbusy_b[0]), 64'h0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("z_clr_any_b", 64'(any_b), 64'h0);

    // Scoreboard set then resolve by write-back
    drv(0, 0, 0, 3, 3, 1, 3);
    chk("sb_set_same_cyc", 64'(rbusy_a), 64'h0);
    tick();
    drv(0, 0, 0, 3, 3, 0, 0);
    chk("sb_busy_r3", 64'(rbusy_a), 64'h3);
    chk("sb_any_set", 64'(any_a), 64'h1);
    drv(1, 3, 32'h55, 3, 3, 0, 0);
    chk("sb_resolve_rbusy", 64'(rbusy_a), 64'h0);
    chk("sb_resolve_rdata", 64'(rdata_a[31:0]), 64'h55);
    chk("sb_any_ignores_wr", 64'(any_a), 64'h1);
    tick();
    drv(0, 0, 0, 3, 3, 0, 0);
    chk("sb_cleared", 64'(rbusy_a), 64'h0);
    chk("sb_any_clear", 64'(any_a), 64'h0);

    // Set and write to the same register: data lands, busy stays set
    drv(1, 9, 32'h99, 9, 9, 1, 9);
    tick();
    drv(0, 0, 0, 9, 9, 0, 0);
    chk("sw_same_data", 64'(rdata_a[31:0]), 64'h99);
    chk("sw_same_busy", 64'(rbusy_a), 64'h3);
    chk("sw_same_any", 64'(any_a), 64'h1);

    // Set and write to different registers
    drv(1, 10, 32'h1010, 4, 10, 1, 4);
    tick();
    drv(0, 0, 0, 4, 10, 0, 0);
    chk("sw_diff_busy", 64'(rbusy_a), 64'h1);
    chk("sw_diff_data", 64'(rdata_a[63:32]), 64'h1010);

    // Write to a non-busy register leaves it clear
    drv(1, 11, 32'hBB, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 9, 11, 0, 0);
    chk("nb_wr_busy", 64'(rbusy_a), 64'h1);
    chk("nb_wr_data", 64'(rdata_a[63:32]), 64'hBB);

    // Asynchronous reset mid-run wipes data and pending busy bits
    rst = 1'b1;
    #1;
    chk("mid_rst_rdata", rdata_a, 64'h0);
    chk("mid_rst_rbusy", 64'(rbusy_a), 64'h0);
    chk("mid_rst_any", 64'(any_a), 64'h0);
    drv(1, 12, 32'hC0DE, 12, 7, 1, 12);
    chk("mid_rst_no_byp", rdata_a, 64'h0);
    tick();
    rst = 1'b0;
    drv(0, 0, 0, 5, 12, 0, 0);
    tick();
    chk("after_rst_r5", 64'(rdata_a[31:0]), 64'h0);
    chk("after_rst_r12", 64'(rdata_a[63:32]), 64'h0);
    chk("after_rst_any", 64'(any_a), 64'h0);
    drv(0, 0, 0, 9, 7, 0, 0);
    chk("after_rst_r9", rdata_a, 64'h0);

    // Random traffic against an array model on the wide instance
    for (int r = 0; r < 16; r++) begin
      m_rf[r]   = '0;
      m_busy[r] = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      we_w    = ($urandom_range(0, 1) == 1);
      waddr_w = 4'($urandom_range(0, 15));
      wdata_w = {$urandom(), $urandom()};
      set_w   = ($urandom_range(0, 2) == 0);
      saddr_w = ($urandom_range(0, 3) == 0) ? waddr_w : 4'($urandom_range(0, 15));
      for (int p = 0; p < 3; p++) begin
        ra = ($urandom_range(0, 2) == 0) ? waddr_w : 4'($urandom_range(0, 15));
        raddr_w[p*4 +: 4] = ra;
      end
      #1;
      for (int p = 0; p < 3; p++) begin
        ra = raddr_w[p*4 +: 4];
        if (ra == 0) begin
          exp_d = '0; exp_b = 1'b0;
        end else if (we_w && waddr_w == ra) begin
          exp_d = wdata_w; exp_b = 1'b0;
        end else begin
          exp_d = m_rf[ra]; exp_b = m_busy[ra];
        end
        chk($sformatf("rnd_c%0d_p%0d_r%0d_data", cyc, p, ra), rdata_w[p*64 +: 64], exp_d);
        chk($sformatf("rnd_c%0d_p%0d_r%0d_busy", cyc, p, ra), 64'(rbusy_w[p]), 64'(exp_b));
      end
      exp_any = 1'b0;
      for (int r = 0; r < 16; r++) exp_any = exp_any | m_busy[r];
      chk($sformatf("rnd_c%0d_any", cyc), 64'(any_w), 64'(exp_any));
      if (we_w && waddr_w != 0) begin
        m_rf[waddr_w]   = wdata_w;
        m_busy[waddr_w] = 1'b0;
      end
      if (set_w && saddr_w != 0) m_busy[saddr_w] = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_regfile.md
# pipe_regfile

Parametrised general-purpose register file for the pipelined CPU core, replacing the fixed 32x32, two-read single-cycle register file. It provides NUM_RD combinational read ports with write-to-read bypass from the write-back port, an optional hard-wired zero register, asynchronous clear of all registers, and a per-register busy scoreboard. The scoreboard marks registers that have an outstanding long-latency writer (load or multi-cycle op). It sits between the decode stage (reads and busy checks) and write-back (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0, and writes and busy-sets to it are ignored

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write-back write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, combinational
- rbusy  out  NUM_RD  per read port: the addressed register has a pending writer that is not resolved this cycle
- set_busy  in  1  issue stage marks a register as having a pending writer
- set_addr  in  ADDR_W  register to mark busy
- any_busy  out  1  OR of all busy bits; used for drain or flush checks

## Operation
- Storage: NREG x DATA_W register array plus an NREG-bit busy vector.
- Write: on the rising clk edge with we=1, rf[waddr] <= wdata and busy[waddr] <= 0. If ZERO_REG=1 and waddr=0, nothing happens.
- Read port i, in priority order:
  - ZERO_REG=1 and addr=0 -> 0
  - we=1 and waddr=addr (write not suppressed) -> wdata (same-cycle bypass)
  - otherwise -> rf[addr]
- rbusy[i] = busy[addr] & ~(we & waddr==addr). The bypassed write resolves the hazard in the same cycle. With ZERO_REG=1 and addr=0, rbusy[i]=0.
- Set: on the rising edge with set_busy=1, busy[set_addr] <= 1. Ignored when ZERO_REG=1 and set_addr=0.
- Set and write to the same address in the same cycle: the register takes wdata and busy ends at 1. A new producer has issued, so the set wins over the clear.
- Set and write to different addresses: both take effect.
- A write to a register that is not busy is legal and leaves busy at 0.
- any_busy is combinational from the busy vector only. It does not account for the current-cycle write.

## Timing
- Read latency 0: rdata and rbusy are combinational from raddr, we, waddr, wdata and state.
- Write and set take effect at the next rising edge and are visible through storage from the following cycle. The bypass makes the write visible in its own cycle.
- Reset asserts asynchronously: all rf entries = 0, all busy = 0.
  - While rst=1: rdata = 0, rbusy = 0, any_busy = 0, and we and set_busy are ignored.
  - The first write is accepted at the first rising edge after rst deasserts.
- Reset mid-operation: all pending busy bits are lost. The pipeline flushes on reset, so this is required behaviour.
- No X propagation: after reset, reads of never-written registers return 0.

## Structure
- Package pipe_regfile_pkg holds:
  - the default DATA_W and ADDR_W localparams shared with decode and write-back
  - a function that extracts slice i from packed raddr and rdata
- Sub-module regfile_scoreboard (parameters ADDR_W, ZERO_REG) owns:
  - the busy vector
  - set/clear priority
  - rbusy masking and any_busy
- The top level holds the data array, the read muxes with bypass, and NUM_RD port generation.

## Test plan
- Reset: assert rst mid-run after several writes -> all rdata=0, any_busy=0 immediately; after release, read r5 -> 0.
- Write/readback: we=1 waddr=7 wdata=0xDEADBEEF -> same cycle rdata[port0] with raddr=7 = 0xDEADBEEF (bypass); next cycle from storage = 0xDEADBEEF; port1 on raddr=8 = 0.
- Zero register: ZERO_REG=1, write 0x1234 to r0 and set_busy r0 -> rdata=0, rbusy=0. Repeat with ZERO_REG=0 -> r0 reads 0x1234.
- Scoreboard: set_busy r3 -> next cycle rbusy=1 for raddr=3 and any_busy=1. Write r3=0x55 -> same cycle rbusy=0 and rdata=0x55; next cycle busy clear, any_busy=0.
- Simultaneous set and write to r9 -> r9=wdata, busy[9]=1 afterwards. Set r4 with write r10 -> busy[4]=1, busy[10]=0, r10 updated.
- Parameter sweep: DATA_W=64, ADDR_W=4, NUM_RD=3 -> random writes and reads on all ports match a reference model over 10k cycles, including r15 at the top of the array.
